// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-port memory-bus arbiter.
// Round-robin behaviour is selected with the ARB_ROUND_ROBIN_EN macro.
package bus_arbiter_pkg;

    localparam int unsigned ADR_WIDTH     = 16;
    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and memory-side signals of the bus arbiter.
// The arbiter uses the slave modport; requesters/memory use the master modport.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADR_W  = ADR_WIDTH,
    parameter int unsigned DATA_W = DATA_WIDTH
);
    logic              req0;
    logic              req1;
    logic [ADR_W-1:0]  adr0;
    logic [ADR_W-1:0]  adr1;
    logic              rw0;
    logic              rw1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic [ADR_W-1:0]  mem_adr;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        dbg_owner;

    modport slave (
        input  req0, req1, adr0, adr1, rw0, rw1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rdata, mem_en, mem_adr, mem_rw, mem_wdata, dbg_owner
    );

    modport master (
        output req0, req1, adr0, adr1, rw0, rw1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rdata, mem_en, mem_adr, mem_rw, mem_wdata, dbg_owner
    );

endinterface

// File: rtl/bus_arbiter_pick.sv
// Combinational next-owner selection for the bus arbiter.
// ARB_ROUND_ROBIN_EN adds last-served tie-break and burst preemption.
module bus_arbiter_pick
    import bus_arbiter_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       last_i,
    input  logic       burst_done_i,
`endif
    input  arb_state_t state_i,
    output arb_state_t state_o
);

    always_comb begin
        state_o = IDLE;
        case (state_i)
            IDLE: begin
                if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_o = (last_i == PORT_CPU) ? OWN1 : OWN0;
`else
                    state_o = OWN0;
`endif
                end else if (req0_i) begin
                    state_o = OWN0;
                end else if (req1_i) begin
                    state_o = OWN1;
                end
            end
            OWN0: begin
                if (!req0_i) begin
                    state_o = req1_i ? OWN1 : IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                end else if (burst_done_i && req1_i) begin
                    state_o = OWN1;
`endif
                end else begin
                    state_o = OWN0;
                end
            end
            OWN1: begin
                if (!req1_i) begin
                    state_o = req0_i ? OWN0 : IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                end else if (burst_done_i && req0_i) begin
                    state_o = OWN0;
`endif
                end else begin
                    state_o = OWN1;
                end
            end
            default: state_o = IDLE;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-port memory-bus arbiter: grant FSM, burst counter and memory-side mux.
// ARB_ROUND_ROBIN_EN selects round-robin with MAX_BURST preemption; else fixed priority.
module bus_arbiter
    import bus_arbiter_pkg::*;
`ifdef ARB_ROUND_ROBIN_EN
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
)
`endif
(
    input logic            clk,
    input logic            reset,
    bus_arbiter_if.slave   bus_io
);

    arb_state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

`ifdef ARB_ROUND_ROBIN_EN
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic            last_q, last_d;
    logic            burst_done;
    logic            cur_req;

    // Counter saturates at MAX_BURST, so a late-arriving contender still preempts.
    assign burst_done = (32'(burst_cnt_q) + 32'd1) >= MAX_BURST;
    assign cur_req    = ((state_q == OWN0) && bus_io.req0) || ((state_q == OWN1) && bus_io.req1);

    bus_arbiter_pick u_pick (
        .req0_i       (bus_io.req0),
        .req1_i       (bus_io.req1),
        .last_i       (last_q),
        .burst_done_i (burst_done),
        .state_i      (state_q),
        .state_o      (state_d)
    );

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_d == OWN0)      last_d = PORT_CPU;
            else if (state_d == OWN1) last_d = PORT_DMA;
        end else if (cur_req && (32'(burst_cnt_q) < MAX_BURST)) begin
            burst_cnt_d = burst_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt_q <= '0;
            last_q      <= PORT_DMA;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
        end
    end
`else
    bus_arbiter_pick u_pick (
        .req0_i  (bus_io.req0),
        .req1_i  (bus_io.req1),
        .state_i (state_q),
        .state_o (state_d)
    );
`endif

    assign bus_io.gnt0      = (state_q == OWN0);
    assign bus_io.gnt1      = (state_q == OWN1);
    assign bus_io.dbg_owner = {bus_io.gnt1, bus_io.gnt0};
    assign bus_io.rdata     = bus_io.mem_rdata;

    always_comb begin
        bus_io.mem_en    = 1'b0;
        bus_io.mem_rw    = RW_READ;
        bus_io.mem_adr   = '0;
        bus_io.mem_wdata = '0;
        case (state_q)
            OWN0: begin
                bus_io.mem_en    = bus_io.req0;
                bus_io.mem_rw    = bus_io.rw0;
                bus_io.mem_adr   = bus_io.adr0;
                bus_io.mem_wdata = bus_io.wdata0;
            end
            OWN1: begin
                bus_io.mem_en    = bus_io.req1;
                bus_io.mem_rw    = bus_io.rw1;
                bus_io.mem_adr   = bus_io.adr1;
                bus_io.mem_wdata = bus_io.wdata1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter; expectations follow ARB_ROUND_ROBIN_EN like the DUT.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int MB = MAX_BURST_DEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Reference model: owner (-1 idle), transfers in current tenure, last port granted.
    int m_owner;
    int m_xfers;
    int m_last;

    bus_arbiter_if bus ();

    bus_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        logic r [2];
        int   nxt;
        r[0] = bus.req0;
        r[1] = bus.req1;
        nxt  = m_owner;
        if (m_owner < 0) begin
            if (r[0] && r[1]) nxt = RR ? 1 - m_last : 0;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
        end else begin
            int o = m_owner;
            int p = 1 - m_owner;
            if (!r[o]) begin
                nxt = r[p] ? p : -1;
            end else begin
                m_xfers++;
                if (RR && m_xfers >= MB && r[p]) nxt = p;
            end
        end
        if (nxt != m_owner) begin
            m_xfers = 0;
            if (nxt >= 0) m_last = nxt;
        end
        m_owner = nxt;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.adr0      = '0;
        bus.adr1      = '0;
        bus.rw0       = RW_READ;
        bus.rw1       = RW_READ;
        bus.wdata0    = '0;
        bus.wdata1    = '0;
        bus.mem_rdata = '0;
        m_owner       = -1;
        m_xfers       = 0;
        m_last        = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.req0   = 1'b1;
        bus.adr0   = 16'h8000;
        bus.rw0    = RW_WRITE;
        bus.wdata0 = 8'hA5;
        tick();
        tick();
        total++;
        if (bus.gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_gnt0: got %b want 1", bus.gnt0);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.gnt1, bus.gnt0, bus.mem_en, bus.mem_rw, bus.dbg_owner} !== 6'b000100) begin
            bad++;
            $display("FAIL reset_async_ctrl: got %b want 000100",
                     {bus.gnt1, bus.gnt0, bus.mem_en, bus.mem_rw, bus.dbg_owner});
        end
        total++;
        if ({bus.mem_adr, bus.mem_wdata} !== 24'h0) begin
            bad++;
            $display("FAIL reset_async_bus: got %h want 000000", {bus.mem_adr, bus.mem_wdata});
        end
        @(posedge clk);
        #1;
        total++;
        if ({bus.gnt1, bus.gnt0, bus.mem_en} !== 3'b000) begin
            bad++;
            $display("FAIL reset_held: got %b want 000", {bus.gnt1, bus.gnt0, bus.mem_en});
        end
        do_reset();
    endtask

    task automatic test_single();
        int xfers = 0;
        do_reset();
        bus.req0   = 1'b1;
        bus.adr0   = 16'h8000;
        bus.rw0    = RW_READ;
        bus.wdata0 = 8'h3C;
        #1;
        total++;
        if ({bus.gnt0, bus.mem_en} !== 2'b00) begin
            bad++;
            $display("FAIL single_before_edge: got %b want 00", {bus.gnt0, bus.mem_en});
        end
        tick();
        total++;
        if ({bus.gnt0, bus.mem_en, bus.mem_rw, bus.mem_adr} !== {3'b111, 16'h8000}) begin
            bad++;
            $display("FAIL single_grant: got %h want %h",
                     {bus.gnt0, bus.mem_en, bus.mem_rw, bus.mem_adr}, {3'b111, 16'h8000});
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.gnt0 && bus.req0) xfers++;
            bus.adr0 = 16'h8000 + 16'(i);
            tick();
        end
        total++;
        if (xfers != 10 || bus.gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL single_burst: got xfers=%0d gnt0=%b want xfers=10 gnt0=1",
                     xfers, bus.gnt0);
        end
    endtask

    task automatic test_tie();
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        total++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            bad++;
            $display("FAIL tie_first: got %b want 01", {bus.gnt1, bus.gnt0});
        end
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        total++;
        if ({bus.gnt1, bus.gnt0} !== 2'b00) begin
            bad++;
            $display("FAIL tie_idle: got %b want 00", {bus.gnt1, bus.gnt0});
        end
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        total++;
        if ({bus.gnt1, bus.gnt0} !== (RR ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL tie_second: got %b want %b", {bus.gnt1, bus.gnt0}, RR ? 2'b10 : 2'b01);
        end
    endtask

    task automatic test_write_mux();
        do_reset();
        bus.req1      = 1'b1;
        bus.rw1       = RW_WRITE;
        bus.adr1      = 16'h0200;
        bus.wdata1    = 8'h5A;
        bus.adr0      = 16'h1234;
        bus.wdata0    = 8'hEE;
        bus.rw0       = RW_READ;
        bus.mem_rdata = 8'hC3;
        tick();
        total++;
        if ({bus.gnt1, bus.mem_en, bus.mem_rw, bus.mem_adr, bus.mem_wdata, bus.dbg_owner}
            !== {3'b110, 16'h0200, 8'h5A, 2'b10}) begin
            bad++;
            $display("FAIL write_mux: got %h want %h",
                     {bus.gnt1, bus.mem_en, bus.mem_rw, bus.mem_adr, bus.mem_wdata, bus.dbg_owner},
                     {3'b110, 16'h0200, 8'h5A, 2'b10});
        end
        bus.req0 = 1'b1;
        #1;
        total++;
        if ({bus.mem_adr, bus.mem_wdata, bus.rdata} !== {16'h0200, 8'h5A, 8'hC3}) begin
            bad++;
            $display("FAIL write_mux_ignore_p0: got %h want %h",
                     {bus.mem_adr, bus.mem_wdata, bus.rdata}, {16'h0200, 8'h5A, 8'hC3});
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (RR) want = (((i - 1) / MB) % 2 == 0) ? 2'b01 : 2'b10;
            else    want = 2'b01;
            total++;
            if ({bus.gnt1, bus.gnt0} !== want) begin
                bad++;
                $display("FAIL contention_cycle%0d: got %b want %b", i, {bus.gnt1, bus.gnt0}, want);
            end
        end
        bus.req0 = 1'b0;
        tick();
        total++;
        if ({bus.gnt1, bus.gnt0} !== 2'b10) begin
            bad++;
            $display("FAIL contention_drop0: got %b want 10", {bus.gnt1, bus.gnt0});
        end
    endtask

    task automatic test_random();
        logic [37:0] got, exp;
        logic        can0, can1, e_en, e_rw;
        logic [15:0] e_adr;
        logic [7:0]  e_wd, rd;
        do_reset();
        can0 = 1'b1;
        can1 = 1'b1;
        for (int i = 0; i < 600; i++) begin
            // Requesters only change their request once it has been served or was idle.
            if (can0) begin
                bus.req0   = ($urandom_range(0, 9) < 7);
                bus.adr0   = 16'($urandom);
                bus.rw0    = 1'($urandom);
                bus.wdata0 = 8'($urandom);
            end
            if (can1) begin
                bus.req1   = ($urandom_range(0, 9) < 7);
                bus.adr1   = 16'($urandom);
                bus.rw1    = 1'($urandom);
                bus.wdata1 = 8'($urandom);
            end
            rd            = 8'($urandom);
            bus.mem_rdata = rd;
            #1;
            e_en  = 1'b0;
            e_rw  = RW_READ;
            e_adr = '0;
            e_wd  = '0;
            if (m_owner == 0) begin
                e_en = bus.req0; e_rw = bus.rw0; e_adr = bus.adr0; e_wd = bus.wdata0;
            end else if (m_owner == 1) begin
                e_en = bus.req1; e_rw = bus.rw1; e_adr = bus.adr1; e_wd = bus.wdata1;
            end
            exp = {m_owner == 1, m_owner == 0, e_en, e_rw, e_adr, e_wd, rd,
                   m_owner == 1, m_owner == 0};
            got = {bus.gnt1, bus.gnt0, bus.mem_en, bus.mem_rw, bus.mem_adr, bus.mem_wdata,
                   bus.rdata, bus.dbg_owner};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_cycle%0d: got %h want %h", i, got, exp);
            end
            can0 = !bus.req0 || (m_owner == 0);
            can1 = !bus.req1 || (m_owner == 1);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_write_mux();
        test_contention();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
